mux_bit_serializer: RTL and testbench

Bit-serial sequencer that drives the team's 2:1 mux cell one bit per cycle and reassembles its output into a parallel word. Loads two WIDTH-bit operands and a per-bit select mask on a start pulse, streams bit i of each (LSB first) onto the mux inputs, captures the mux output each cycle, and signals done with the assembled word. Sits directly upstream and downstream of the mux: it feeds s0/s1/select and consumes out.

---
 rtl/mux_bit_serializer_pkg.sv | 12 +
 rtl/mux_bit_serializer.sv | 122 ++++++++++++
 tb/tb_mux_bit_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mux_bit_serializer_pkg.sv
// Shared types and constants for the bit-serial 2:1 mux sequencer.
package mux_bit_serializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/mux_bit_serializer.sv
// Streams two latched operands and a select mask LSB-first into an external
// 2:1 mux and reassembles the mux output into a parallel result word.
module mux_bit_serializer
   import mux_bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] sel_mask,
   output logic             s0_bit,
   output logic             s1_bit,
   output logic             sel_bit,
   input  logic             mux_out,
   output logic             busy,
   output logic             bit_valid,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_a_sh;
   logic [WIDTH-1:0]  r_b_sh;
   logic [WIDTH-1:0]  r_m_sh;
   logic [WIDTH-1:0]  r_acc;
   logic [WIDTH-1:0]  r_result;
   logic              r_busy;
   logic              r_bit_valid;
   logic              r_done;
   logic              w_load;
   logic              w_shift;
   logic              w_last;
   logic [WIDTH-1:0]  w_acc_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == LAST_IDX) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Captured bit enters at the MSB so the first bit lands at bit 0 after WIDTH shifts
   assign w_acc_nxt = {mux_out, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_m_sh   <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (w_load) begin
         r_cnt  <= '0;
         r_a_sh <= a;
         r_b_sh <= b;
         r_m_sh <= sel_mask;
         r_acc  <= '0;
      end else if (w_shift) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_a_sh <= r_a_sh >> 1;
         r_b_sh <= r_b_sh >> 1;
         r_m_sh <= r_m_sh >> 1;
         r_acc  <= w_acc_nxt;
         if (w_last) r_result <= w_acc_nxt;
      end
   end

   // Status flags registered from the next state so they align with r_state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy      <= 1'b0;
         r_bit_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt == ST_SHIFT);
         r_bit_valid <= (w_state_nxt == ST_SHIFT);
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   assign s0_bit    = r_a_sh[0];
   assign s1_bit    = r_b_sh[0];
   assign sel_bit   = r_m_sh[0];
   assign busy      = r_busy;
   assign bit_valid = r_bit_valid;
   assign done      = r_done;
   assign result    = r_result;

endmodule

// File: tb/tb_mux_bit_serializer.sv
// Self-checking bench for mux_bit_serializer with a behavioural 2:1 mux cell.
module tb_mux_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] sel_mask = '0;
   logic         s0_bit, s1_bit, sel_bit, mux_out;
   logic         busy, bit_valid, done;
   logic [W-1:0] result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // The 2:1 mux cell: select=1 chooses s0, select=0 chooses s1
   assign mux_out = sel_bit ? s0_bit : s1_bit;

   mux_bit_serializer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .sel_mask(sel_mask),
      .s0_bit(s0_bit), .s1_bit(s1_bit), .sel_bit(sel_bit),
      .mux_out(mux_out),
      .busy(busy), .bit_valid(bit_valid), .done(done), .result(result)
   );

   function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [W-1:0] mm);
      return (ma & mm) | (mb & ~mm);
   endfunction

   // Runs one operation from IDLE, returns observations, and leaves the DUT in IDLE
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im,
                        input bit scramble, output logic [W-1:0] res, output int nbusy,
                        output int dcyc, output logic [W-1:0] s0q, output logic [W-1:0] s1q,
                        output logic [W-1:0] selq);
      int k;
      @(negedge clk);
      a = ia; b = ib; sel_mask = im; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0; dcyc = -1; k = 0;
      res = '0; s0q = '0; s1q = '0; selq = '0;
      for (int c = 1; c <= W + 6; c++) begin
         if (busy) nbusy++;
         if (bit_valid && k < W) begin
            s0q[k] = s0_bit; s1q[k] = s1_bit; selq[k] = sel_bit;
            k++;
         end
         if (done) begin
            dcyc = c;
            res = result;
            break;
         end
         if (scramble) begin
            a = W'($urandom); b = W'($urandom); sel_mask = W'($urandom);
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
      checks++; if ({s0_bit, s1_bit, sel_bit} !== 3'b000) begin
         failures++; $display("FAIL reset_mux_bits got=%b exp=000", {s0_bit, s1_bit, sel_bit});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] va[3] = '{8'hF0, 8'hF0, 8'hFF};
      logic [W-1:0] vb[3] = '{8'h0F, 8'h0F, 8'h00};
      logic [W-1:0] vm[3] = '{8'hFF, 8'h00, 8'hAA};
      logic [W-1:0] exp_r[3] = '{8'hF0, 8'h0F, 8'hAA};
      logic [W-1:0] res, s0q, s1q, selq;
      int nbusy, dcyc;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], vm[i], 1'b0, res, nbusy, dcyc, s0q, s1q, selq);
         checks++; if (res !== exp_r[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, exp_r[i]); end
         checks++; if (nbusy != W) begin failures++; $display("FAIL directed_busy_cycles[%0d] got=%0d exp=%0d", i, nbusy, W); end
         checks++; if (dcyc != W + 1) begin failures++; $display("FAIL directed_done_cycle[%0d] got=%0d exp=%0d", i, dcyc, W + 1); end
         checks++; if (selq !== vm[i]) begin failures++; $display("FAIL directed_sel_seq[%0d] got=%h exp=%h", i, selq, vm[i]); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, rm, res, s0q, s1q, selq;
      int nbusy, dcyc;
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom); rb = W'($urandom); rm = W'($urandom);
         do_op(ra, rb, rm, 1'b0, res, nbusy, dcyc, s0q, s1q, selq);
         checks++; if (res !== model(ra, rb, rm)) begin
            failures++; $display("FAIL random_result a=%h b=%h m=%h got=%h exp=%h", ra, rb, rm, res, model(ra, rb, rm));
         end
         checks++; if ({s0q, s1q, selq} !== {ra, rb, rm}) begin
            failures++; $display("FAIL random_streams got=%h/%h/%h exp=%h/%h/%h", s0q, s1q, selq, ra, rb, rm);
         end
         checks++; if (dcyc != W + 1) begin failures++; $display("FAIL random_latency got=%0d exp=%0d", dcyc, W + 1); end
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int dc[$];
      logic [W-1:0] dr[$];
      @(negedge clk);
      a = 8'h3C; b = 8'hC3; sel_mask = 8'h0F; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 20) start = 1'b0;
         if (done) begin ndone++; dc.push_back(c); dr.push_back(result); end
      end
      checks++; if (ndone != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
      if (ndone == 2) begin
         checks++; if (dc[1] - dc[0] != W + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", dc[1] - dc[0], W + 2); end
         checks++; if (dr[0] !== 8'hCC || dr[1] !== 8'hCC) begin failures++; $display("FAIL b2b_result got=%h,%h exp=cc,cc", dr[0], dr[1]); end
         checks++; if (dc[0] != W + 1) begin failures++; $display("FAIL b2b_first_done got=%0d exp=%0d", dc[0], W + 1); end
      end
   endtask

   task automatic test_input_change();
      logic [W-1:0] res, s0q, s1q, selq;
      int nbusy, dcyc;
      do_op(8'h55, 8'hAA, 8'hF0, 1'b1, res, nbusy, dcyc, s0q, s1q, selq);
      checks++; if (res !== 8'h5A) begin failures++; $display("FAIL scramble_result got=%h exp=5a", res); end
      checks++; if (selq !== 8'hF0) begin failures++; $display("FAIL scramble_sel_seq got=%h exp=f0", selq); end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] res, s0q, s1q, selq;
      int nbusy, dcyc;
      @(negedge clk);
      a = 8'h96; b = 8'h69; sel_mask = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (busy !== 1'b0 || bit_valid !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", busy, bit_valid, done);
      end
      checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result got=%h exp=00", result); end
      do_op(8'h96, 8'h69, 8'h3C, 1'b0, res, nbusy, dcyc, s0q, s1q, selq);
      checks++; if (res !== model(8'h96, 8'h69, 8'h3C)) begin
         failures++; $display("FAIL midrst_recover got=%h exp=%h", res, model(8'h96, 8'h69, 8'h3C));
      end
   endtask

   task automatic test_idle_hold();
      logic [W-1:0] res, s0q, s1q, selq, exp_r;
      int nbusy, dcyc;
      exp_r = model(8'hE7, 8'h18, 8'h5A);
      do_op(8'hE7, 8'h18, 8'h5A, 1'b0, res, nbusy, dcyc, s0q, s1q, selq);
      for (int c = 0; c < 5; c++) begin
         checks++; if (result !== exp_r) begin failures++; $display("FAIL idle_result[%0d] got=%h exp=%h", c, result, exp_r); end
         checks++; if (bit_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_flags[%0d] got=%b%b%b exp=000", c, bit_valid, done, busy);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_input_change();
      test_mid_reset();
      test_idle_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
